// File: rtl/div_arbiter_pkg.sv
// Shared constants and state encoding for the two-way divider arbiter.
package div_arbiter_pkg;
    localparam int NREQ  = 2;
    localparam int W_DEF = 20;

    // Quotient reported for a divide-by-zero job.
    localparam logic [W_DEF-1:0] DZ_QUO = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } state_t;
endpackage

// File: rtl/div_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker; the caller owns the `last` register.
module rr_arb2
    import div_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            last,
    output logic            any,
    output logic            winner
);
    assign any = |req;
    // On a tie, favour whoever was not served last.
    assign winner = (req == 2'b11) ? ~last : req[1];
endmodule

// File: rtl/div_arbiter.sv
// Shares one start/done sequential divider between two requesters, round-robin,
// with divide-by-zero answered locally without starting the divider.
module div_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] dvnd_in,
    input  logic [NREQ*W-1:0] dvsr_in,
    output logic [NREQ-1:0]   done_tick,
    output logic [W-1:0]      quo,
    output logic [W-1:0]      rmd,
    output logic              dz,
    output logic              busy,
    output logic              owner,
    output logic              div_start,
    output logic [W-1:0]      div_dvnd,
    output logic [W-1:0]      div_dvsr,
    input  logic [W-1:0]      div_quo,
    input  logic [W-1:0]      div_rmd,
    input  logic              div_done_tick
);
    state_t     r_state;
    logic       r_owner;
    logic       r_last;
    logic [W-1:0] r_dvnd;
    logic [W-1:0] r_dvsr;
    logic [W-1:0] r_quo;
    logic [W-1:0] r_rmd;
    logic       r_dz;

    logic       w_any;
    logic       w_winner;
    logic [W-1:0] w_sel_dvnd;
    logic [W-1:0] w_sel_dvsr;

    rr_arb2 u_rr (
        .req    (req),
        .last   (r_last),
        .any    (w_any),
        .winner (w_winner)
    );

    assign w_sel_dvnd = w_winner ? dvnd_in[2*W-1:W] : dvnd_in[W-1:0];
    assign w_sel_dvsr = w_winner ? dvsr_in[2*W-1:W] : dvsr_in[W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_dvnd  <= '0;
            r_dvsr  <= '0;
            r_quo   <= '0;
            r_rmd   <= '0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_owner <= w_winner;
                    r_last  <= w_winner;
                    r_dvnd  <= w_sel_dvnd;
                    r_dvsr  <= w_sel_dvsr;
                    if (w_sel_dvsr == '0) begin
                        // Divide-by-zero: answer directly, divider stays idle.
                        r_quo   <= '1;
                        r_rmd   <= w_sel_dvnd;
                        r_dz    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_dz    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: r_state <= WAIT;
                WAIT: if (div_done_tick) begin
                    r_quo   <= div_quo;
                    r_rmd   <= div_rmd;
                    r_state <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign div_start = (r_state == START);
    assign busy      = (r_state != IDLE);
    assign done_tick = (r_state == DONE) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign owner     = r_owner;
    assign quo       = r_quo;
    assign rmd       = r_rmd;
    assign dz        = r_dz;
    assign div_dvnd  = r_dvnd;
    assign div_dvsr  = r_dvsr;
endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider, two requester agents, and a
// round-robin job-order model built from queued jobs.
module tb_div_arbiter;
    import div_arbiter_pkg::*;

    localparam int W = 20;

    typedef struct {
        int           idx;
        logic [W-1:0] quo;
        logic [W-1:0] rmd;
        logic         dz;
    } rec_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   req;
    logic [2*W-1:0] dvnd_in, dvsr_in;
    logic [1:0]   done_tick;
    logic [W-1:0] quo, rmd, div_dvnd, div_dvsr, div_quo, div_rmd;
    logic         dz, busy, owner, div_start, div_done_tick;

    logic         tb_req  [2];
    logic [W-1:0] tb_dvnd [2];
    logic [W-1:0] tb_dvsr [2];

    assign req     = {tb_req[1], tb_req[0]};
    assign dvnd_in = {tb_dvnd[1], tb_dvnd[0]};
    assign dvsr_in = {tb_dvsr[1], tb_dvsr[0]};

    div_arbiter #(.W(W)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .dvnd_in(dvnd_in), .dvsr_in(dvsr_in),
        .done_tick(done_tick), .quo(quo), .rmd(rmd), .dz(dz), .busy(busy), .owner(owner),
        .div_start(div_start), .div_dvnd(div_dvnd), .div_dvsr(div_dvsr),
        .div_quo(div_quo), .div_rmd(div_rmd), .div_done_tick(div_done_tick)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Jobs handed to agents (main writes), expected-order lists (main only).
    logic [W-1:0] jobs_a [2][$];
    logic [W-1:0] jobs_b [2][$];
    logic [W-1:0] p_a    [2][$];
    logic [W-1:0] p_b    [2][$];
    int           pulse_cnt [2];
    int           exp_last = 1;
    rec_t         last_exp;

    rec_t comp_q[$];
    int   comp_rd = 0;

    int   force_lat = 0;
    int   spur_cnt  = 0;
    int   n_starts  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic rec_t ref_div(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        rec_t r;
        r.idx = idx;
        if (b == '0) begin r.quo = DZ_QUO; r.rmd = a; r.dz = 1'b1; end
        else begin r.quo = a / b; r.rmd = a % b; r.dz = 1'b0; end
        return r;
    endfunction

    task automatic add_job(input int g, input logic [W-1:0] a, input logic [W-1:0] b, input bit predicted);
        jobs_a[g].push_back(a);
        jobs_b[g].push_back(b);
        if (predicted) begin p_a[g].push_back(a); p_b[g].push_back(b); end
    endtask

    // Round-robin order: alternate while both have work, else drain the one that does.
    task automatic predict_and_check(input string tag);
        rec_t exp[$];
        int t;
        while (p_a[0].size() > 0 || p_a[1].size() > 0) begin
            int w;
            if (p_a[0].size() > 0 && p_a[1].size() > 0) w = (exp_last == 0) ? 1 : 0;
            else w = (p_a[0].size() > 0) ? 0 : 1;
            exp_last = w;
            exp.push_back(ref_div(w, p_a[w].pop_front(), p_b[w].pop_front()));
        end
        t = 0;
        while (comp_q.size() < comp_rd + exp.size() && t < 3000) begin tick(1); t++; end
        chk({tag, ".timeout"}, comp_q.size() >= comp_rd + exp.size(), 1);
        foreach (exp[k]) begin
            rec_t g;
            if (comp_q.size() <= comp_rd) break;
            g = comp_q[comp_rd];
            comp_rd++;
            chk({tag, ".idx"}, g.idx, exp[k].idx);
            chk({tag, ".quo"}, g.quo, exp[k].quo);
            chk({tag, ".rmd"}, g.rmd, exp[k].rmd);
            chk({tag, ".dz"},  g.dz,  exp[k].dz);
            last_exp = exp[k];
        end
    endtask

    // Requester agents: hold req until done_tick, then drop it for at least one cycle.
    for (genvar g = 0; g < 2; g++) begin : g_agent
        initial begin
            int nxt = 0;
            int pseen = 0;
            bit pulsing = 0;
            tb_req[g] = 1'b0; tb_dvnd[g] = '0; tb_dvsr[g] = '0;
            forever begin
                @(posedge clk); #1;
                if (!reset_n) begin
                    tb_req[g] = 1'b0; pulsing = 0;
                    nxt = jobs_a[g].size(); pseen = pulse_cnt[g];
                end else if (pulsing) begin
                    tb_req[g] = 1'b0; pulsing = 0;
                end else if (tb_req[g] && done_tick[g]) begin
                    tb_req[g] = 1'b0; nxt++;
                end else if (tb_req[g] && busy && owner == g) begin
                    tb_dvnd[g] = W'($urandom); tb_dvsr[g] = W'($urandom);
                end else if (!tb_req[g] && pseen != pulse_cnt[g]) begin
                    pseen = pulse_cnt[g]; pulsing = 1; tb_req[g] = 1'b1;
                    tb_dvnd[g] = W'($urandom); tb_dvsr[g] = W'($urandom);
                end else if (!tb_req[g] && nxt < jobs_a[g].size()) begin
                    tb_dvnd[g] = jobs_a[g][nxt]; tb_dvsr[g] = jobs_b[g][nxt]; tb_req[g] = 1'b1;
                end
            end
        end
    end

    // Behavioural divider with variable latency; reset abandons the job.
    initial begin
        bit d_pend = 0;
        int d_cnt = 0;
        int spur_seen = 0;
        logic [W-1:0] d_a = '0, d_b = '0;
        div_done_tick = 1'b0; div_quo = '0; div_rmd = '0;
        forever begin
            @(posedge clk); #1;
            div_done_tick = 1'b0;
            if (!reset_n) d_pend = 0;
            else if (d_pend) begin
                if (d_cnt == 0) begin
                    div_done_tick = 1'b1;
                    div_quo = (d_b == '0) ? '1 : d_a / d_b;
                    div_rmd = (d_b == '0) ? d_a : d_a % d_b;
                    d_pend = 0;
                end else d_cnt--;
            end else if (div_start) begin
                n_starts++;
                d_a = div_dvnd; d_b = div_dvsr; d_pend = 1;
                d_cnt = (force_lat > 0) ? force_lat : int'($urandom_range(0, 4));
            end else if (!busy && spur_seen != spur_cnt) begin
                spur_seen = spur_cnt;
                div_done_tick = 1'b1; div_quo = W'($urandom); div_rmd = W'($urandom);
            end
        end
    end

    // Protocol monitor and completion recorder.
    logic       m_pbusy = 1'b0, m_pstart = 1'b0, m_pdd = 1'b0, m_prst = 1'b0;
    logic [1:0] m_preq = 2'b00;
    initial forever begin
        @(negedge clk);
        if (reset_n && m_prst) begin
            if (div_start) begin
                chk("start_follows_grant", (!m_pbusy && m_preq != 2'b00), 1);
                chk("start_one_cycle", m_pstart, 0);
            end
            if (done_tick != 2'b00) begin
                rec_t r;
                chk("done_onehot", done_tick, owner ? 2'b10 : 2'b01);
                chk("done_follows_cause", (m_pdd && m_pbusy) || (!m_pbusy && m_preq != 2'b00), 1);
                r.idx = done_tick[1] ? 1 : 0; r.quo = quo; r.rmd = rmd; r.dz = dz;
                comp_q.push_back(r);
            end
        end
        m_pbusy = busy; m_pstart = div_start; m_pdd = div_done_tick;
        m_preq = req; m_prst = reset_n;
    end

    initial begin
        int s;
        reset_n = 1'b0;
        tick(2);
        chk("rst.done_tick", done_tick, 2'b00);
        chk("rst.quo", quo, 0);
        chk("rst.rmd", rmd, 0);
        chk("rst.dz", dz, 0);
        chk("rst.busy", busy, 0);
        chk("rst.owner", owner, 0);
        chk("rst.div_start", div_start, 0);
        chk("rst.div_dvnd", div_dvnd, 0);
        chk("rst.div_dvsr", div_dvsr, 0);
        @(negedge clk) reset_n = 1'b1;

        @(negedge clk); add_job(0, 20'd1000000, 20'd250, 1);
        predict_and_check("single");
        chk("single.quo_const", quo, 4000);
        chk("single.owner", owner, 0);
        chk("single.div_dvnd", div_dvnd, 1000000);
        chk("single.div_dvsr", div_dvsr, 250);

        reset_n = 1'b0; tick(2);
        @(negedge clk) reset_n = 1'b1; exp_last = 1;
        @(negedge clk);
        add_job(0, 20'd1000000, 20'd7, 1);
        add_job(1, 20'd1000000, 20'd3, 1);
        predict_and_check("tie");
        chk("tie.last_quo", quo, 333333);

        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            add_job(0, W'($urandom), W'($urandom_range(1, 4000)), 1);
            add_job(1, W'($urandom), W'($urandom_range(1, 4000)), 1);
        end
        predict_and_check("alt");

        s = n_starts;
        @(negedge clk); add_job(1, 20'd12345, 20'd0, 1);
        predict_and_check("dz");
        chk("dz.no_start", n_starts, s);
        chk("dz.quo", quo, DZ_QUO);
        chk("dz.owner", owner, 1);

        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            int sel;
            logic [W-1:0] b;
            sel = int'($urandom_range(0, 3));
            b = (sel == 0) ? '0 : (sel == 1) ? W'($urandom_range(1, 15)) : W'($urandom);
            add_job(int'($urandom_range(0, 1)), W'($urandom), b, 1);
        end
        predict_and_check("rand");

        tick(3);
        spur_cnt++;
        tick(5);
        chk("spur.quo", quo, last_exp.quo);
        chk("spur.rmd", rmd, last_exp.rmd);
        chk("spur.busy", busy, 0);
        chk("spur.no_done", comp_q.size(), comp_rd);

        force_lat = 12;
        @(negedge clk); add_job(0, W'($urandom), W'($urandom_range(1, 999)), 1);
        tick(4);
        chk("wd.busy", busy, 1);
        pulse_cnt[1]++;
        predict_and_check("wd");
        tick(2);
        chk("wd.idle", busy, 0);
        tick(10);
        chk("wd.no_done1", comp_q.size(), comp_rd);

        force_lat = 30;
        @(negedge clk); add_job(0, 20'd777777, 20'd13, 0);
        tick(5);
        chk("mid.in_wait", (busy && !div_start), 1);
        reset_n = 1'b0; #1;
        chk("mid.busy", busy, 0);
        chk("mid.done_tick", done_tick, 2'b00);
        chk("mid.div_start", div_start, 0);
        chk("mid.quo", quo, 0);
        chk("mid.rmd", rmd, 0);
        chk("mid.owner", owner, 0);
        chk("mid.div_dvnd", div_dvnd, 0);
        tick(3);
        @(negedge clk) reset_n = 1'b1; exp_last = 1; force_lat = 0;
        tick(20);
        chk("mid.no_done", comp_q.size(), comp_rd);
        @(negedge clk);
        add_job(0, 20'd999999, 20'd1000, 1);
        add_job(1, 20'd500000, 20'd9, 1);
        predict_and_check("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one sequential divider (`div`, W-bit operands, start/done_tick handshake) between two requesters, e.g. two frequency/period measurement channels.
- Arbitration is round-robin.
- Captures the winner's operands, sequences the divider's start pulse, collects the quotient and remainder, and returns them to the winner with a one-cycle done pulse.
- Short-circuits divide-by-zero without using the divider.

Parameters:
- W, 20, operand/result width; must match the attached divider's W.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  2  req[i]: requester i wants a division; held high until done_tick[i]
- dvnd_in  in  2*W  dividends; requester i at [i*W +: W]
- dvsr_in  in  2*W  divisors; requester i at [i*W +: W]
- done_tick  out  2  done_tick[i]: one-cycle pulse, result for requester i valid
- quo  out  W  registered quotient of the last completed operation
- rmd  out  W  registered remainder of the last completed operation
- dz  out  1  registered flag: last completed operation had divisor 0
- busy  out  1  high in any state other than IDLE
- owner  out  1  index of the requester currently or last served
- div_start  out  1  one-cycle start pulse to the divider
- div_dvnd  out  W  dividend to the divider, from the internal register
- div_dvsr  out  W  divisor to the divider, from the internal register
- div_quo  in  W  divider quotient
- div_rmd  in  W  divider remainder
- div_done_tick  in  1  divider completion pulse

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE.
  - quo, rmd, operand registers = 0; dz=0, owner=0.
  - done_tick=0, div_start=0, busy=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - The divider is reset by the same signal; reset mid-operation abandons the job with no done_tick.
- States: IDLE, START, WAIT, DONE. Moore outputs: div_start=(state==START); done_tick[owner]=(state==DONE); busy=(state!=IDLE).
- IDLE:
  - Nothing happens if req==0.
  - Otherwise select the winner: if only one req bit is set, that one; if both are set, the index != last.
  - On that edge: owner<=winner, last<=winner, and capture dvnd/dvsr of the winner into the operand registers.
  - Captured dvsr==0: state<=DONE, quo<=all ones, rmd<=captured dvnd, dz<=1 (divider not started).
  - Otherwise: dz<=0, state<=START.
- START: div_start=1 for exactly one cycle; state<=WAIT.
- WAIT:
  - On div_done_tick: quo<=div_quo, rmd<=div_rmd, state<=DONE.
  - Otherwise hold.
  - No timeout.
- DONE: done_tick[owner]=1 for one cycle; state<=IDLE.
- Latency:
  - Request sampled at edge k: div_start high in cycle k+1.
  - done_tick high in the cycle after the edge sampling div_done_tick.
  - Divide-by-zero: done_tick high in cycle k+1.
  - Back-to-back service: at least 1 IDLE cycle between jobs.
- Requester rules:
  - Operands need only be stable in the cycle req is sampled in IDLE.
  - The requester must drop req on the edge where it samples done_tick high. If it does not, it is treated as a new request and round-robin applies.
  - req dropped before grant = withdrawn; no done_tick.
  - req changes of the non-owner during START/WAIT/DONE are ignored until IDLE.
- Outputs:
  - quo/rmd/dz hold until the next completion; valid whenever done_tick is high.
  - div_dvnd/div_dvsr are stable from START until the next IDLE capture.
- Spurious div_done_tick in IDLE, START or DONE is ignored.

Decomposition:
- Shared package: state encoding localparams (IDLE=2'b00, START=2'b01, WAIT=2'b10, DONE=2'b11); NREQ=2; DZ_QUO constant (all ones, W bits).
- Sub-module: rr_arb2, a combinational 2-way round-robin picker (inputs req[1:0], last; outputs any, winner). The arbiter keeps the `last` register.
- The divider is not instantiated inside the arbiter; the top level wires div_* ports to it.

Test Plan:
- Only req[0], dvnd=1_000_000, dvsr=250 -> div_start one cycle after sampling; done_tick=2'b01 one cycle after div_done_tick; quo=4000, rmd=0, dz=0, owner=0.
- Both req high, job0 (1_000_000/7), job1 (1_000_000/3) -> requester 0 served first (quo=142857, rmd=1); then requester 1 (quo=333333, rmd=1); exactly one done_tick per requester.
- Both req held continuously, re-raised immediately after each done -> grants alternate 0,1,0,1 over 4 jobs; no starvation.
- req[1] with dvsr=0, dvnd=12345 -> done_tick[1] in the cycle after sampling; quo=20'hFFFFF, rmd=12345, dz=1; div_start never asserted.
- Reset mid-operation: reset_n low during WAIT -> all outputs return to reset values immediately; no done_tick; next request after release is served normally, with requester 0 winning a tie.
- Withdrawn request: req[1] pulsed for 1 cycle while busy on requester 0 -> no done_tick[1]; busy falls after requester 0 completes.
